// File: rtl/ram_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ram_rw_arbiter
// Round-robin front-end mapping NUM_CH ram_rw requesters onto one RAMHelper port.
// Revision: 1.0
// ============================================================================
module ram_rw_arbiter #(
   parameter int                NUM_CH    = 2,
   parameter int                DATA_W    = 64,
   parameter int                ADDR_W    = 64,
   parameter int                IDX_W     = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
   parameter int                LATENCY   = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          ch_cen_i,
   input  logic [NUM_CH-1:0]          ch_wen_i,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_i,
   input  logic [NUM_CH*DATA_W-1:0]   ch_wdata_i,
   input  logic [NUM_CH*DATA_W/8-1:0] ch_wmask_i,
   input  logic [NUM_CH*3-1:0]        ch_size_i,
   output logic [NUM_CH-1:0]          ch_ready_o,
   output logic [NUM_CH-1:0]          ch_err_o,
   output logic [NUM_CH*DATA_W-1:0]   ch_rdata_o,
   output logic                       mem_en_o,
   output logic                       mem_wen_o,
   output logic [IDX_W-1:0]           mem_ridx_o,
   output logic [IDX_W-1:0]           mem_widx_o,
   output logic [DATA_W-1:0]          mem_wdata_o,
   output logic [DATA_W-1:0]          mem_wmask_o,
   input  logic [DATA_W-1:0]          mem_rdata_i,
   output logic                       busy_o
);

   localparam int BW   = DATA_W / 8;
   localparam int SH   = $clog2(BW);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                     state_q;
   logic [CH_W-1:0]            rr_q;
   logic [CH_W-1:0]            ch_q;
   logic                       wen_q;
   logic                       err_q;
   logic [2:0]                 cnt_q;
   logic [DATA_W-1:0]          resp_q;
   logic [NUM_CH*DATA_W-1:0]   rdata_q;
   logic [NUM_CH-1:0]          ready_q;
   logic [NUM_CH-1:0]          cherr_q;
   logic                       mem_en_q;
   logic                       mem_wen_q;
   logic [IDX_W-1:0]           idx_q;
   logic [DATA_W-1:0]          wdata_q;
   logic [DATA_W-1:0]          wmask_q;

   logic                       gnt_vld_d;
   logic [CH_W-1:0]            gnt_d;
   logic [ADDR_W-1:0]          sel_addr_d;
   logic [2:0]                 sel_size_d;
   logic                       sel_wen_d;
   logic [DATA_W-1:0]          sel_wdata_d;
   logic [BW-1:0]              sel_bmask_d;
   logic [ADDR_W-1:0]          off_d;
   logic [ADDR_W-1:0]          word_d;
   logic [ADDR_W-1:0]          align_d;
   logic                       err_d;
   logic [DATA_W-1:0]          wmask_d;
   logic [DATA_W-1:0]          rd_val_d;

   // First requesting channel at or above the round-robin pointer, wrapping.
   always_comb begin
      gnt_vld_d = 1'b0;
      gnt_d     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!gnt_vld_d && ch_cen_i[(int'(rr_q) + i) % NUM_CH]) begin
            gnt_vld_d = 1'b1;
            gnt_d     = CH_W'((int'(rr_q) + i) % NUM_CH);
         end
      end
   end

   always_comb begin
      sel_addr_d  = ch_addr_i[int'(gnt_d)*ADDR_W +: ADDR_W];
      sel_size_d  = ch_size_i[int'(gnt_d)*3 +: 3];
      sel_wen_d   = ch_wen_i[gnt_d];
      sel_wdata_d = ch_wdata_i[int'(gnt_d)*DATA_W +: DATA_W];
      sel_bmask_d = ch_wmask_i[int'(gnt_d)*BW +: BW];
      off_d       = sel_addr_d - BASE_ADDR;
      word_d      = off_d >> SH;
      align_d     = sel_addr_d & ~({ADDR_W{1'b1}} << sel_size_d);
      err_d       = (sel_addr_d < BASE_ADDR) || ((word_d >> IDX_W) != '0) ||
                    (sel_size_d > 3'(SH)) || (align_d != '0);
      wmask_d     = '0;
      for (int b = 0; b < BW; b++) begin
         wmask_d[8*b +: 8] = {8{sel_bmask_d[b]}};
      end
   end

   // A rejected read returns zero rather than whatever the memory drives.
   assign rd_val_d = err_q ? '0 : mem_rdata_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rr_q      <= '0;
         ch_q      <= '0;
         wen_q     <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         resp_q    <= '0;
         rdata_q   <= '0;
         ready_q   <= '0;
         cherr_q   <= '0;
         mem_en_q  <= 1'b0;
         mem_wen_q <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (gnt_vld_d) begin
                  ch_q      <= gnt_d;
                  wen_q     <= sel_wen_d;
                  err_q     <= err_d;
                  mem_en_q  <= ~err_d;
                  mem_wen_q <= ~err_d & sel_wen_d;
                  idx_q     <= word_d[IDX_W-1:0];
                  wdata_q   <= sel_wdata_d;
                  wmask_q   <= wmask_d;
                  state_q   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               mem_en_q  <= 1'b0;
               mem_wen_q <= 1'b0;
               idx_q     <= '0;
               wdata_q   <= '0;
               wmask_q   <= '0;
               if (!wen_q) resp_q <= rd_val_d;
               if (LATENCY > 1) begin
                  cnt_q   <= 3'(LATENCY - 2);
                  state_q <= S_WAIT;
               end else begin
                  // No wait stage: the response slice is loaded straight from memory.
                  ready_q[ch_q] <= 1'b1;
                  cherr_q[ch_q] <= err_q;
                  if (!wen_q) rdata_q[int'(ch_q)*DATA_W +: DATA_W] <= rd_val_d;
                  state_q <= S_RESP;
               end
            end
            S_WAIT: begin
               if (cnt_q == 3'd0) begin
                  ready_q[ch_q] <= 1'b1;
                  cherr_q[ch_q] <= err_q;
                  if (!wen_q) rdata_q[int'(ch_q)*DATA_W +: DATA_W] <= resp_q;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_RESP: begin
               ready_q <= '0;
               cherr_q <= '0;
               if (int'(ch_q) == NUM_CH - 1) rr_q <= '0;
               else                          rr_q <= ch_q + 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ch_ready_o  = ready_q;
   assign ch_err_o    = cherr_q;
   assign ch_rdata_o  = rdata_q;
   assign mem_en_o    = mem_en_q;
   assign mem_wen_o   = mem_wen_q;
   assign mem_ridx_o  = idx_q;
   assign mem_widx_o  = idx_q;
   assign mem_wdata_o = wdata_q;
   assign mem_wmask_o = wmask_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_rw_arbiter
// Random requests against a transaction-level model, plus latency/reset scenarios.
// Revision: 1.0
// ============================================================================
module tb_ram_rw_arbiter;

   localparam int          NCH    = 2;
   localparam int          DW     = 64;
   localparam int          AW     = 64;
   localparam int          IW     = 8;
   localparam logic [63:0] BASE   = 64'h8000_0000;
   localparam int          LAT_A  = 1;
   localparam int          LAT_B  = 3;
   localparam int          NCYC_A = 600;

   typedef struct packed {
      logic        wen;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } req_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] init_word(input int i);
      if (i == 2) return 64'hDEADBEEF_CAFEF00D;
      return {32'(i) * 32'h9E3779B9, ~(32'(i) * 32'h85EBCA6B)};
   endfunction

   function automatic logic [63:0] expand(input logic [7:0] m);
      logic [63:0] r;
      for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
      return r;
   endfunction

   function automatic bit req_err(input logic [63:0] addr, input logic [2:0] size);
      logic [63:0] off;
      if (addr < BASE) return 1'b1;
      off = addr - BASE;
      if ((off / 8) >= (64'd1 << IW)) return 1'b1;
      if (size > 3) return 1'b1;
      if ((addr % (64'd1 << size)) != 0) return 1'b1;
      return 1'b0;
   endfunction

   // ---------------- DUT A: LATENCY 1, random traffic ----------------
   logic              rst_n_a = 1'b0;
   logic [NCH-1:0]    a_cen, a_wen, a_ready, a_err;
   logic [NCH*AW-1:0] a_addr;
   logic [NCH*DW-1:0] a_wdata, a_rdata;
   logic [NCH*8-1:0]  a_wmask;
   logic [NCH*3-1:0]  a_size;
   logic              a_men, a_mwen, a_busy;
   logic [IW-1:0]     a_ridx, a_widx;
   logic [DW-1:0]     a_mwdata, a_mwmask, a_mrdata;

   ram_rw_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .IDX_W(IW),
                    .BASE_ADDR(BASE), .LATENCY(LAT_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n_a),
      .ch_cen_i(a_cen), .ch_wen_i(a_wen), .ch_addr_i(a_addr), .ch_wdata_i(a_wdata),
      .ch_wmask_i(a_wmask), .ch_size_i(a_size),
      .ch_ready_o(a_ready), .ch_err_o(a_err), .ch_rdata_o(a_rdata),
      .mem_en_o(a_men), .mem_wen_o(a_mwen), .mem_ridx_o(a_ridx), .mem_widx_o(a_widx),
      .mem_wdata_o(a_mwdata), .mem_wmask_o(a_mwmask), .mem_rdata_i(a_mrdata),
      .busy_o(a_busy));

   logic [63:0] a_mem [256];
   assign a_mrdata = a_mem[a_ridx];
   always @(posedge clk) begin
      if (!rst_n_a) begin
         for (int i = 0; i < 256; i++) a_mem[i] <= init_word(i);
      end else if (a_men && a_mwen) begin
         a_mem[a_widx] <= (a_mem[a_widx] & ~a_mwmask) | (a_mwdata & a_mwmask);
      end
   end

   // ---------------- DUT B: LATENCY 3, directed read-only ----------------
   logic              rst_n_b = 1'b0;
   logic [NCH-1:0]    b_cen, b_wen, b_ready, b_err;
   logic [NCH*AW-1:0] b_addr;
   logic [NCH*DW-1:0] b_wdata, b_rdata;
   logic [NCH*8-1:0]  b_wmask;
   logic [NCH*3-1:0]  b_size;
   logic              b_men, b_mwen, b_busy;
   logic [IW-1:0]     b_ridx, b_widx;
   logic [DW-1:0]     b_mwdata, b_mwmask, b_mrdata;

   ram_rw_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .IDX_W(IW),
                    .BASE_ADDR(BASE), .LATENCY(LAT_B)) u_dut_b (
      .clk(clk), .rst_n(rst_n_b),
      .ch_cen_i(b_cen), .ch_wen_i(b_wen), .ch_addr_i(b_addr), .ch_wdata_i(b_wdata),
      .ch_wmask_i(b_wmask), .ch_size_i(b_size),
      .ch_ready_o(b_ready), .ch_err_o(b_err), .ch_rdata_o(b_rdata),
      .mem_en_o(b_men), .mem_wen_o(b_mwen), .mem_ridx_o(b_ridx), .mem_widx_o(b_widx),
      .mem_wdata_o(b_mwdata), .mem_wmask_o(b_mwmask), .mem_rdata_i(b_mrdata),
      .busy_o(b_busy));

   assign b_mrdata = init_word(int'(b_ridx));

   // ---------------- stimulus helpers ----------------
   task automatic set_req(input int k, input req_t r);
      a_cen[k]              = 1'b1;
      a_wen[k]              = r.wen;
      a_addr[k*AW +: AW]    = r.addr;
      a_size[k*3 +: 3]      = r.size;
      a_wdata[k*DW +: DW]   = r.wdata;
      a_wmask[k*8 +: 8]     = r.wmask;
   endtask

   function automatic req_t rand_req();
      req_t        r;
      int          kind;
      int          sz;
      logic [63:0] idx;
      kind    = int'($urandom_range(0, 9));
      r.wen   = 1'($urandom_range(0, 1));
      r.wdata = {$urandom, $urandom};
      r.wmask = 8'($urandom);
      idx     = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255)) : 64'($urandom_range(0, 15));
      sz      = int'($urandom_range(0, 3));
      r.size  = 3'(sz);
      r.addr  = BASE + (idx << 3) + ((64'($urandom_range(0, 7)) >> sz) << sz);
      case (kind)
         0: r.addr = BASE - 64'(8 * $urandom_range(1, 4));
         1: r.addr = BASE + 64'd2048 + 64'(8 * $urandom_range(0, 3));
         2: begin
            r.size = 3'($urandom_range(1, 3));
            r.addr = BASE + (idx << 3) + 64'd1;
         end
         3: r.size = 3'($urandom_range(4, 7));
         default: ;
      endcase
      return r;
   endfunction

   // ---------------- reference model state ----------------
   logic [63:0] ref_mem [256];
   logic [63:0] exp_rdata [NCH];
   req_t        dir_tab [NCH][3];
   int          dir_n [NCH];
   bit          txn, issue, e_err, e_wen;
   int          g, t_gnt, t_rdy, next_free, rr_m, e_idx, k;
   logic [63:0] e_wmask, e_wdata, e_rd, e_addr;
   int          mem_diff;

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      for (int i = 0; i < NCH; i++) begin
         exp_rdata[i] = '0;
         dir_n[i]     = 0;
      end
      dir_tab[0][0] = '{wen: 1'b0, addr: BASE + 64'h10, size: 3'd3, wdata: 64'd0, wmask: 8'h00};
      dir_tab[0][1] = '{wen: 1'b0, addr: BASE + 64'h8, size: 3'd3, wdata: 64'd0, wmask: 8'h00};
      dir_tab[0][2] = '{wen: 1'b0, addr: BASE + 64'd2048, size: 3'd3, wdata: 64'd0, wmask: 8'h00};
      dir_tab[1][0] = '{wen: 1'b1, addr: BASE + 64'h8, size: 3'd3, wdata: 64'h11223344_55667788, wmask: 8'h0F};
      dir_tab[1][1] = '{wen: 1'b0, addr: BASE - 64'h8, size: 3'd3, wdata: 64'd0, wmask: 8'h00};
      dir_tab[1][2] = '{wen: 1'b0, addr: BASE + 64'h2, size: 3'd2, wdata: 64'd0, wmask: 8'h00};
      txn = 1'b0; g = 0; t_gnt = -10; t_rdy = -10; next_free = 0; rr_m = 0;
      e_err = 1'b0; e_wen = 1'b0; e_idx = 0; e_wmask = '0; e_wdata = '0; e_rd = '0; e_addr = '0;

      a_cen = '0; a_wen = '0; a_addr = '0; a_wdata = '0; a_wmask = '0; a_size = '0;
      b_cen = '0; b_wen = '0; b_addr = '0; b_wdata = '0; b_wmask = '0; b_size = {NCH{3'd3}};

      repeat (3) @(posedge clk);
      #1;
      check_eq("a_rst_ready", 64'(a_ready), 64'd0);
      check_eq("a_rst_busy", 64'(a_busy), 64'd0);
      check_eq("a_rst_men", 64'({a_men, a_mwen}), 64'd0);
      check_eq("a_rst_rdata", 64'(|a_rdata), 64'd0);
      check_eq("b_rst_busy", 64'(b_busy), 64'd0);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;

      // Cycle t begins just after the t-th rising edge following reset release.
      for (int t = 0; t < NCYC_A; t++) begin
         issue = txn && (t == t_gnt + 1);
         check_eq("a_ready", 64'(a_ready), (txn && t == t_rdy) ? (64'd1 << g) : 64'd0);
         check_eq("a_busy", 64'(a_busy), 64'(txn && t > t_gnt && t <= t_rdy));
         check_eq("a_mem_en", 64'(a_men), 64'(issue && !e_err));
         if (issue) begin
            check_eq("a_mem_wen", 64'(a_mwen), 64'(e_wen && !e_err));
            if (!e_err) begin
               check_eq("a_ridx", 64'(a_ridx), 64'(e_idx));
               check_eq("a_widx", 64'(a_widx), 64'(e_idx));
               if (e_wen) begin
                  check_eq("a_wdata", a_mwdata, e_wdata);
                  check_eq("a_wmask", a_mwmask, e_wmask);
               end
            end
         end else begin
            check_eq("a_mem_quiet", 64'(|{a_ridx, a_widx, a_mwdata, a_mwmask, a_mwen}), 64'd0);
         end
         if (txn && t == t_rdy) begin
            check_eq("a_err", 64'(a_err[g]), 64'(e_err));
            if (!e_wen) exp_rdata[g] = e_rd;
            for (int c = 0; c < NCH; c++) check_eq("a_rdata", a_rdata[c*DW +: DW], exp_rdata[c]);
            a_cen[g] = 1'b0;
            txn      = 1'b0;
         end else begin
            check_eq("a_err_idle", 64'(a_err), 64'd0);
         end

         for (int c = 0; c < NCH; c++) begin
            if (!a_cen[c] && t < NCYC_A - 20) begin
               if (dir_n[c] < 3) begin
                  set_req(c, dir_tab[c][dir_n[c]]);
                  dir_n[c]++;
               end else if ($urandom_range(0, 9) < 7) begin
                  set_req(c, rand_req());
               end
            end
         end

         if (t >= next_free && (|a_cen)) begin
            for (int i = 0; i < NCH; i++) begin
               k = (rr_m + i) % NCH;
               if (!txn && a_cen[k]) begin
                  txn = 1'b1;
                  g   = k;
               end
            end
            e_addr  = a_addr[g*AW +: AW];
            e_wen   = a_wen[g];
            e_err   = req_err(e_addr, a_size[g*3 +: 3]);
            e_wdata = a_wdata[g*DW +: DW];
            e_wmask = expand(a_wmask[g*8 +: 8]);
            e_rd    = '0;
            if (!e_err) begin
               e_idx = int'((e_addr - BASE) / 8);
               if (e_wen) ref_mem[e_idx] = (ref_mem[e_idx] & ~e_wmask) | (e_wdata & e_wmask);
               else       e_rd = ref_mem[e_idx];
            end
            t_gnt     = t;
            t_rdy     = t + 1 + LAT_A;
            next_free = t_rdy + 1;
            rr_m      = (g + 1) % NCH;
         end
         @(posedge clk);
         #1;
      end
      check_eq("a_drained", 64'(txn), 64'd0);
      mem_diff = 0;
      for (int i = 0; i < 256; i++) if (a_mem[i] !== ref_mem[i]) mem_diff++;
      check_eq("a_mem_image", 64'(mem_diff), 64'd0);

      // ---- B1: single read with LATENCY 3 ----
      b_addr[0 +: AW] = BASE + 64'h18;
      b_cen = 2'b01;
      for (int c = 0; c < 7; c++) begin
         check_eq("b_mem_en", 64'(b_men), 64'(c == 1));
         check_eq("b_busy", 64'(b_busy), 64'(c >= 1 && c <= 4));
         check_eq("b_ready", 64'(b_ready), (c == 4) ? 64'd1 : 64'd0);
         if (c == 1) check_eq("b_ridx", 64'(b_ridx), 64'd3);
         if (c == 4) begin
            check_eq("b_rdata0", b_rdata[0 +: DW], init_word(3));
            check_eq("b_err", 64'(b_err), 64'd0);
            b_cen = 2'b00;
         end
         @(posedge clk);
         #1;
      end

      // ---- B2: pointer now at ch1; reset while ch1's access is in WAIT ----
      b_addr[0 +: AW]  = BASE + 64'h20;
      b_addr[AW +: AW] = BASE + 64'h28;
      b_cen = 2'b11;
      for (int c = 0; c < 2; c++) begin
         if (c == 1) check_eq("b_rr_grant1", 64'(b_ridx), 64'd5);
         @(posedge clk);
         #1;
      end
      check_eq("b_busy_wait", 64'(b_busy), 64'd1);
      #2 rst_n_b = 1'b0;
      #1;
      check_eq("b_async_ready", 64'({b_ready, b_err}), 64'd0);
      check_eq("b_async_rdata0", b_rdata[0 +: DW], 64'd0);
      check_eq("b_async_rdata1", b_rdata[DW +: DW], 64'd0);
      check_eq("b_async_mem", 64'(|{b_men, b_mwen, b_ridx, b_widx, b_mwdata, b_mwmask}), 64'd0);
      check_eq("b_async_busy", 64'(b_busy), 64'd0);
      b_cen = 2'b00;
      @(posedge clk);
      #1;
      rst_n_b = 1'b1;
      for (int c = 0; c < 6; c++) begin
         check_eq("b_no_ready", 64'({b_ready, b_busy}), 64'd0);
         @(posedge clk);
         #1;
      end
      b_cen = 2'b11;
      for (int c = 0; c < 6; c++) begin
         if (c == 1) check_eq("b_rr_after_rst", 64'(b_ridx), 64'd4);
         check_eq("b_ready2", 64'(b_ready), (c == 4) ? 64'd1 : 64'd0);
         if (c == 4) begin
            check_eq("b_rdata_reissue", b_rdata[0 +: DW], init_word(4));
            b_cen = 2'b00;
         end
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram_rw_arbiter.md
# ram_rw_arbiter

Parametrised memory front-end between one or more `ram_rw`-style requesters (e.g. instruction fetch and LSU) and a single-port `RAMHelper`-style memory. Provides round-robin arbitration across `NUM_CH` channels, BASE-relative word-index translation and byte-mask expansion. It also adds a configurable response latency and alignment/range error reporting. It replaces direct wiring of one core port to the memory model in the simulation top.

## Interface

Parameters:
- `NUM_CH`, default 2: number of requester channels, 1..4.
- `DATA_W`, default 64: memory word width; power of two, at least 32.
- `ADDR_W`, default 64: requester address width.
- `IDX_W`, default 16: memory word-index width.
- `BASE_ADDR`, default `PC_START`: byte address of memory index 0.
- `LATENCY`, default 1: cycles from memory issue to `ready`, 1..8.

Ports (`BW` = `DATA_W/8`, `SH` = log2(`BW`)):
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ch_cen_i`  in  `NUM_CH`  per-channel request valid.
- `ch_wen_i`  in  `NUM_CH`  1 = write, 0 = read.
- `ch_addr_i`  in  `NUM_CH*ADDR_W`  byte address; channel k is at slice k.
- `ch_wdata_i`  in  `NUM_CH*DATA_W`  write data.
- `ch_wmask_i`  in  `NUM_CH*BW`  byte write enables.
- `ch_size_i`  in  `NUM_CH*3`  access size; bytes = 1<<size.
- `ch_ready_o`  out  `NUM_CH`  one-cycle completion pulse.
- `ch_err_o`  out  `NUM_CH`  valid only with `ready`; 1 = request rejected.
- `ch_rdata_o`  out  `NUM_CH*DATA_W`  read word; held until that channel's next completion.
- `mem_en_o`  out  1  memory enable.
- `mem_wen_o`  out  1  memory write enable.
- `mem_ridx_o`, `mem_widx_o`  out  `IDX_W`  word index; both carry the same value.
- `mem_wdata_o`  out  `DATA_W`  write data.
- `mem_wmask_o`  out  `DATA_W`  bit mask; byte i of `ch_wmask_i` is replicated to bits [8i+7:8i].
- `mem_rdata_i`  in  `DATA_W`  read data, valid combinationally from `mem_ridx_o`.
- `busy_o`  out  1  FSM not in IDLE.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `ch_cen_i` is set, grant the first set channel searching upward, modulo `NUM_CH`, from the round-robin pointer `rr`.
  - Latch the granted channel's wen, addr, wdata, wmask, size and the channel number. Go to ISSUE.
  - Otherwise stay in IDLE.
- **Error check at grant**, registered as `err`. The request is an error if any of:
  - `addr < BASE_ADDR`;
  - `(addr-BASE_ADDR)>>SH` ≥ 2^`IDX_W`;
  - `(1<<size) > BW`;
  - `addr` is not aligned to `1<<size`.
- **ISSUE**, 1 cycle
  - `mem_en_o = ~err`; `mem_wen_o = ~err & wen`.
  - Index = `((addr-BASE_ADDR)>>SH)[IDX_W-1:0]`.
  - On a read, capture `mem_rdata_i` into a response register; on an error, capture 0.
  - On a write, memory commits at the end of ISSUE. Read-response data is left unchanged.
  - Go to WAIT if `LATENCY>1`, else RESP.
- **WAIT**
  - Down-counter loaded with `LATENCY-2` on entry; exit to RESP when it reaches 0.
  - `mem_en_o` is 0 throughout.
- **RESP**, 1 cycle
  - `ch_ready_o[g]=1`, `ch_err_o[g]=err`.
  - On a read, `ch_rdata_o` slice g is updated from the response register.
  - `rr` ← (g+1) mod `NUM_CH`. Go to IDLE.
- **Requester rule**
  - Hold `cen` and the payload stable until `ready` is seen.
  - `cen` sampled in the cycle after `ready` is treated as a new request.
- All `mem_*` outputs other than the enables are 0 outside ISSUE.
- Only one access is outstanding at a time; other channels wait in IDLE arbitration.

## Timing

- Request first sampled in IDLE at cycle 0:
  - ISSUE in cycle 1;
  - `ready` in cycle `1+LATENCY`;
  - earliest next grant in cycle `2+LATENCY`.
- Throughput: one access per `LATENCY+2` cycles.
- Simultaneous requests: exactly one grant per IDLE visit. Losing channels are not starved; worst-case wait is `(NUM_CH-1)*(LATENCY+2)` cycles.
- **Reset values** while `rst_n` is low, asynchronous:
  - all `ch_ready_o`, `ch_err_o`, `ch_rdata_o` = 0;
  - all `mem_*` outputs = 0, `busy_o` = 0;
  - state IDLE, `rr` = 0, counter = 0.
- **Reset mid-operation**
  - In ISSUE before the edge: the write is not committed.
  - In WAIT or RESP: no `ready` is produced.
  - Requesters must re-issue after reset.
- Pointer wrap: grant to `NUM_CH-1` sets `rr`=0.
- `NUM_CH=1`: `rr` is constant 0; behaviour is otherwise identical.

## Test plan

- **Single read**, `LATENCY=1`, ch0 reads `BASE_ADDR+0x10`, memory word 2 = `0xDEADBEEF_CAFEF00D`:
  - `mem_en_o=1`, `mem_ridx_o=2` in cycle 1;
  - `ch_ready_o=01` in cycle 2, `ch_rdata_o[0]=0xDEADBEEF_CAFEF00D`, `ch_err_o=0`.
- **Masked write then read-back**:
  - ch1 writes `0x11223344_55667788` to `BASE_ADDR+8`, size 3, wmask `0x0F`;
  - `mem_wmask_o = 0x00000000_FFFFFFFF`;
  - subsequent read of word 1 returns upper 32 bits unchanged and lower 32 bits = `0x55667788`.
- **Contention**: ch0 and ch1 hold `cen` continuously from reset.
  - Grants alternate 0,1,0,1.
  - `ready` pulses at cycles 2, 5, 8, 11 for `LATENCY=1`.
- **Errors**, each must give `ready` + `err=1`, `mem_en_o` never high, `ch_rdata_o`=0:
  - read of `BASE_ADDR-8`;
  - read of `BASE_ADDR+(1<<(IDX_W+SH))`;
  - size 2 at `BASE_ADDR+2`.
- **`LATENCY=3`**: single read.
  - `mem_en_o` high only in cycle 1;
  - `busy_o` high for cycles 1–4 (ISSUE, two WAIT cycles, RESP);
  - `ready` in cycle 4.
- **Reset in WAIT** (`LATENCY=4`): assert `rst_n=0` in cycle 2.
  - All outputs are 0 immediately.
  - No `ready` follows.
  - After release, a re-issued request completes normally with `rr`=0.
